// File: rtl/mul_sequencer_if.sv
// Handshake and operand bundle between the execute-stage pipeline and mul_sequencer.
// The pipeline side uses the master modport; the sequencer uses the slave modport.
interface mul_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic        set_flags;
    logic [31:0] rm;
    logic [31:0] rs;
    logic [31:0] acc_lo;
    logic [31:0] acc_hi;
    logic        flush;
    logic        res_ready;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        wr_hi;
    logic        flags_we;
    logic        flag_n;
    logic        flag_z;
    logic        illegal_op;

    modport master (
        output start, op, set_flags, rm, rs, acc_lo, acc_hi, flush, res_ready,
        input  busy, done, result_lo, result_hi, wr_hi, flags_we, flag_n, flag_z, illegal_op
    );

    modport slave (
        input  start, op, set_flags, rm, rs, acc_lo, acc_hi, flush, res_ready,
        output busy, done, result_lo, result_hi, wr_hi, flags_we, flag_n, flag_z, illegal_op
    );
endinterface

// File: rtl/mul_sequencer.sv
// ARM7 multiply sequencer with early-termination timing and accumulate/high-word phases.
// Define MUL_LONG_EN to enable UMULL/UMLAL/SMULL/SMLAL and the 64-bit datapath.
module mul_sequencer (
    input  logic           clk,
    input  logic           reset_n,
    mul_sequencer_if.slave bus
);

`ifdef MUL_LONG_EN
    localparam int PW = 64;
`else
    localparam int PW = 32;
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        ACC  = 3'd2,
        HI   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state;

    logic [2:0]           cnt;
    logic                 acc_q;
    logic                 sf_q;
    logic                 long_q;
    logic signed [PW-1:0] rm_p0;
    logic signed [PW-1:0] rs_p0;
    logic signed [PW-1:0] acc_p0;
    logic signed [PW-1:0] sum_p1;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] nxt;
    logic                 fin;

    logic        busy_r;
    logic        done_r;
    logic        wr_hi_r;
    logic        flags_we_r;
    logic        flag_n_r;
    logic        flag_z_r;
    logic        illegal_r;
    logic [31:0] result_lo_r;

    // Operands are extended to PW at latch time, so one wrapping PW-bit
    // multiply serves signed, unsigned and short forms alike.
    function automatic logic [2:0] calc_m(input logic [31:0] v, input logic uns);
        logic [2:0] m;
        if (v[31:8] == 24'd0 || (!uns && &v[31:8]))
            m = 3'd1;
        else if (v[31:16] == 16'd0 || (!uns && &v[31:16]))
            m = 3'd2;
        else if (v[31:24] == 8'd0 || (!uns && &v[31:24]))
            m = 3'd3;
        else
            m = 3'd4;
        return m;
    endfunction

    function automatic logic op_legal(input logic [2:0] o);
`ifdef MUL_LONG_EN
        return o[2] | ~o[1];
`else
        return o[2:1] == 2'b00;
`endif
    endfunction

    function automatic logic [1:0] nz_flags(input logic [PW-1:0] v, input logic lng);
        logic n;
        logic z;
        n = lng ? v[PW-1] : v[31];
        z = lng ? (v == '0) : (v[31:0] == 32'd0);
        return {n, z};
    endfunction

    assign prod = rm_p0 * rs_p0;

    always_comb begin
        nxt = sum_p1;
        fin = 1'b0;
        case (state)
            MUL: begin
                nxt = prod;
                fin = (cnt == 3'd1) && !acc_q && !long_q;
            end
            ACC: begin
                nxt = sum_p1 + acc_p0;
                fin = !long_q;
            end
`ifdef MUL_LONG_EN
            HI: fin = 1'b1;
`endif
            default: ;
        endcase
    end

`ifdef MUL_LONG_EN
    logic [31:0] result_hi_r;
`else
    logic unused_acc_hi;
    assign unused_acc_hi = ^bus.acc_hi;
    assign long_q        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            acc_q       <= 1'b0;
            sf_q        <= 1'b0;
            rm_p0       <= '0;
            rs_p0       <= '0;
            acc_p0      <= '0;
            sum_p1      <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            wr_hi_r     <= 1'b0;
            flags_we_r  <= 1'b0;
            flag_n_r    <= 1'b0;
            flag_z_r    <= 1'b0;
            illegal_r   <= 1'b0;
            result_lo_r <= 32'd0;
`ifdef MUL_LONG_EN
            long_q      <= 1'b0;
            result_hi_r <= 32'd0;
`endif
        end else begin
            illegal_r <= 1'b0;
            if (bus.flush) begin
                state      <= IDLE;
                busy_r     <= 1'b0;
                done_r     <= 1'b0;
                wr_hi_r    <= 1'b0;
                flags_we_r <= 1'b0;
            end else begin
                case (state)
                    // p0: operand capture and iteration count
                    IDLE: begin
                        if (bus.start) begin
                            if (op_legal(bus.op)) begin
                                acc_q  <= bus.op[0];
                                sf_q   <= bus.set_flags;
                                cnt    <= calc_m(bus.rs, bus.op[2] & ~bus.op[1]);
`ifdef MUL_LONG_EN
                                long_q <= bus.op[2];
                                rm_p0  <= {{32{bus.op[1] & bus.rm[31]}}, bus.rm};
                                rs_p0  <= {{32{bus.op[1] & bus.rs[31]}}, bus.rs};
                                acc_p0 <= {(bus.op[2] ? bus.acc_hi : 32'd0), bus.acc_lo};
`else
                                rm_p0  <= bus.rm;
                                rs_p0  <= bus.rs;
                                acc_p0 <= bus.acc_lo;
`endif
                                busy_r <= 1'b1;
                                state  <= MUL;
                            end else begin
                                illegal_r <= 1'b1;
                            end
                        end
                    end
                    // p1: product capture after the early-termination count
                    MUL: begin
                        if (cnt == 3'd1) begin
                            sum_p1 <= nxt;
                            if (acc_q)
                                state <= ACC;
                            else if (long_q)
                                state <= HI;
                            else
                                state <= DONE;
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                    ACC: begin
                        sum_p1 <= nxt;
                        state  <= long_q ? HI : DONE;
                    end
`ifdef MUL_LONG_EN
                    HI: state <= DONE;
`endif
                    DONE: begin
                        if (bus.res_ready) begin
                            state      <= IDLE;
                            busy_r     <= 1'b0;
                            done_r     <= 1'b0;
                            wr_hi_r    <= 1'b0;
                            flags_we_r <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase

                // p2: result and flag registers, held through DONE
                if (fin) begin
                    result_lo_r          <= nxt[31:0];
`ifdef MUL_LONG_EN
                    result_hi_r          <= long_q ? nxt[PW-1:32] : 32'd0;
`endif
                    {flag_n_r, flag_z_r} <= nz_flags(nxt, long_q);
                    done_r               <= 1'b1;
                    wr_hi_r              <= long_q;
                    flags_we_r           <= sf_q;
                end
            end
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.result_lo  = result_lo_r;
    assign bus.flags_we   = flags_we_r;
    assign bus.flag_n     = flag_n_r;
    assign bus.flag_z     = flag_z_r;
    assign bus.illegal_op = illegal_r;
`ifdef MUL_LONG_EN
    assign bus.result_hi  = result_hi_r;
    assign bus.wr_hi      = wr_hi_r;
`else
    assign bus.result_hi  = 32'd0;
    assign bus.wr_hi      = 1'b0;
    logic unused_wr_hi;
    assign unused_wr_hi   = wr_hi_r;
`endif

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed and randomized bench for mul_sequencer against an arithmetic reference model.
module tb_mul_sequencer;

`ifdef MUL_LONG_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mul_sequencer_if bus();

    mul_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle count from the magnitude of rs: smallest byte span that holds it.
    function automatic int model_m(input logic [31:0] rs, input bit uns);
        longint s;
        longint lim;
        s = uns ? longint'({32'd0, rs}) : longint'($signed(rs));
        for (int k = 1; k <= 3; k++) begin
            lim = longint'(1) << (8 * k);
            if (uns && s < lim) return k;
            if (!uns && s >= -lim && s < lim) return k;
        end
        return 4;
    endfunction

    function automatic logic [63:0] model_res(input logic [2:0] op, input logic [31:0] rm,
                                              input logic [31:0] rs, input logic [31:0] alo,
                                              input logic [31:0] ahi);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        if (op[2]) begin
            if (op[1]) begin
                sa = longint'($signed(rm));
                sb = longint'($signed(rs));
                p  = 64'(sa * sb);
            end else begin
                p = {32'd0, rm} * {32'd0, rs};
            end
            if (op[0]) p = p + {ahi, alo};
        end else begin
            p = {32'd0, rm * rs + (op[0] ? alo : 32'd0)};
        end
        return p;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input bit sf,
                          input logic [31:0] rm, input logic [31:0] rs,
                          input logic [31:0] alo, input logic [31:0] ahi,
                          input int stall, input bit hold_start);
        bit          illegal;
        bit          lng;
        int          lat;
        int          c;
        logic [63:0] p;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        bit          exp_n;
        bit          exp_z;

        illegal = (op[2:1] == 2'b01) || (op[2] && !LONG_EN);
        lng     = op[2];
        bus.op = op; bus.set_flags = sf; bus.rm = rm; bus.rs = rs;
        bus.acc_lo = alo; bus.acc_hi = ahi; bus.res_ready = 1'b0;
        bus.start = 1'b1;
        step();

        if (illegal) begin
            bus.start = 1'b0;
            check({tag, ".illegal_pulse"}, 64'(bus.illegal_op), 64'd1);
            check({tag, ".illegal_busy"}, 64'(bus.busy), 64'd0);
            step();
            check({tag, ".illegal_end"}, 64'(bus.illegal_op), 64'd0);
            check({tag, ".illegal_idle"}, 64'(bus.busy), 64'd0);
            return;
        end

        if (!hold_start) bus.start = 1'b0;
        bus.op = 3'($urandom_range(0, 7)); bus.rm = $urandom; bus.rs = $urandom;
        bus.acc_lo = $urandom; bus.acc_hi = $urandom; bus.set_flags = 1'($urandom_range(0, 1));

        p      = model_res(op, rm, rs, alo, ahi);
        lat    = model_m(rs, op[2] && !op[1]) + int'(op[0]) + int'(lng);
        exp_lo = p[31:0];
        exp_hi = lng ? p[63:32] : 32'd0;
        exp_n  = lng ? p[63] : p[31];
        exp_z  = lng ? (p == 64'd0) : (p[31:0] == 32'd0);

        check({tag, ".busy_e0"}, 64'(bus.busy), 64'd1);
        c = 0;
        while (!bus.done && c < 12) begin
            check({tag, ".busy_run"}, 64'(bus.busy), 64'd1);
            step();
            c++;
            check({tag, ".no_illegal"}, 64'(bus.illegal_op), 64'd0);
        end
        check({tag, ".latency"}, 64'(c), 64'(lat));
        bus.start = 1'b0;
        if (!bus.done) return;

        for (int s = 0; s <= stall; s++) begin
            check({tag, ".lo"}, 64'(bus.result_lo), 64'(exp_lo));
            check({tag, ".hi"}, 64'(bus.result_hi), 64'(exp_hi));
            check({tag, ".wr_hi"}, 64'(bus.wr_hi), 64'(lng));
            check({tag, ".flags_we"}, 64'(bus.flags_we), 64'(sf));
            check({tag, ".flag_n"}, 64'(bus.flag_n), 64'(exp_n));
            check({tag, ".flag_z"}, 64'(bus.flag_z), 64'(exp_z));
            check({tag, ".done_hold"}, 64'(bus.done), 64'd1);
            check({tag, ".busy_hold"}, 64'(bus.busy), 64'd1);
            if (s < stall) step();
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check({tag, ".done_drop"}, 64'(bus.done), 64'd0);
        check({tag, ".busy_drop"}, 64'(bus.busy), 64'd0);
        check({tag, ".wr_hi_drop"}, 64'(bus.wr_hi), 64'd0);
        check({tag, ".flags_we_drop"}, 64'(bus.flags_we), 64'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [2:0]  op;
        bit          fill;
        int          k;

        reset_n = 1'b0;
        bus.start = 1'b0; bus.op = 3'd0; bus.set_flags = 1'b0; bus.rm = 32'd0; bus.rs = 32'd0;
        bus.acc_lo = 32'd0; bus.acc_hi = 32'd0; bus.flush = 1'b0; bus.res_ready = 1'b0;
        #2;
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.done", 64'(bus.done), 64'd0);
        check("rst.lo", 64'(bus.result_lo), 64'd0);
        check("rst.hi", 64'(bus.result_hi), 64'd0);
        check("rst.flags", 64'({bus.wr_hi, bus.flags_we, bus.flag_n, bus.flag_z, bus.illegal_op}), 64'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        run_op("mul_3x5", 3'b000, 1'b1, 32'd3, 32'd5, 32'd0, 32'd0, 0, 1'b0);
        run_op("mla", 3'b001, 1'b0, 32'h100, 32'h0001_2345, 32'd7, 32'd0, 0, 1'b0);
        run_op("smull_m1", 3'b110, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 32'd0, 0, 1'b0);
        run_op("umlal_m4", 3'b101, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1'b0);
        run_op("smull_zero", 3'b110, 1'b1, 32'd0, 32'h1234_5678, 32'd0, 32'd0, 0, 1'b0);
        run_op("mul_neg", 3'b000, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 0, 1'b0);
        run_op("mul_zero", 3'b000, 1'b1, 32'd0, 32'hFFFF_FF00, 32'd0, 32'd0, 0, 1'b0);
        run_op("stall3", 3'b001, 1'b1, 32'h8000_0001, 32'h0000_1234, 32'h5, 32'd0, 3, 1'b0);
        run_op("op010", 3'b010, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 0, 1'b0);
        run_op("op011", 3'b011, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 0, 1'b0);
        run_op("start_held", 3'b000, 1'b0, 32'd9, 32'h0100_0000, 32'd0, 32'd0, 1, 1'b1);

        // Abort a four-iteration MUL in its second cycle; a new start is taken right after.
        bus.op = 3'b000; bus.rm = 32'd11; bus.rs = 32'h1234_5678; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_mul.busy", 64'(bus.busy), 64'd0);
        check("flush_mul.done", 64'(bus.done), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("flush_mul.no_done", 64'(bus.done), 64'd0);
        end
        run_op("after_flush", 3'b001, 1'b1, 32'd4, 32'd6, 32'hFFFF_FFE8, 32'd0, 0, 1'b0);

        // Flush while the result is held, and flush winning over start in IDLE.
        bus.op = 3'b000; bus.rm = 32'd3; bus.rs = 32'd5; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        check("flush_done.pre", 64'(bus.done), 64'd1);
        bus.flush = 1'b1;
        step();
        check("flush_done.done", 64'(bus.done), 64'd0);
        check("flush_done.busy", 64'(bus.busy), 64'd0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_start.busy", 64'(bus.busy), 64'd0);

        // Asynchronous reset mid-instruction clears state without a clock edge.
        bus.op = 3'b001; bus.rm = 32'd7; bus.rs = 32'h7FFF_FFFF; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("arst.pre", 64'(bus.busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("arst.busy", 64'(bus.busy), 64'd0);
        check("arst.lo", 64'(bus.result_lo), 64'd0);
        step();
        reset_n = 1'b1;
        step();

        for (int t = 0; t < 60; t++) begin
            op   = 3'($urandom_range(0, 7));
            r    = $urandom;
            k    = $urandom_range(0, 3);
            fill = 1'($urandom_range(0, 1));
            case (k)
                0: r[31:8]  = {24{fill}};
                1: r[31:16] = {16{fill}};
                2: r[31:24] = {8{fill}};
                default: ;
            endcase
            run_op("rand", op, 1'($urandom_range(0, 1)), $urandom, r, $urandom, $urandom,
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
